// File: rtl/led_panel_pkg.sv
// rtl/led_panel_pkg.sv - shared HUB panel constants and types
package led_panel_pkg;
    localparam int PANEL_COLS      = 32;
    localparam int PANEL_ROW_ADDRS = 4;
    localparam int PANEL_HALF_ROWS = 8;
    localparam int ROW_W           = $clog2(PANEL_ROW_ADDRS);
    localparam int HALF_W          = $clog2(PANEL_HALF_ROWS);

    typedef logic [ROW_W-1:0] row_addr_t;

    typedef struct packed {
        logic red;
        logic green;
        logic blue;
    } rgb_t;
endpackage

// File: rtl/led_panel_capture_if.sv
// rtl/led_panel_capture_if.sv - HUB panel pin bundle (driver is master, capture is slave)
interface led_panel_capture_if;
    logic       sclk_in;
    logic       latch_in;
    logic       blank_in;
    logic       aclk_in;
    logic       arst_in;
    logic [2:0] rgb_in;

    modport master (output sclk_in, latch_in, blank_in, aclk_in, arst_in, rgb_in);
    modport slave  (input  sclk_in, latch_in, blank_in, aclk_in, arst_in, rgb_in);
endinterface

// File: rtl/led_panel_sync_edge.sv
// rtl/led_panel_sync_edge.sv - N-stage synchronizer with rise/fall detect on the last stage
module led_panel_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= {STAGES{RESET_VAL}};
            prev  <= RESET_VAL;
        end else begin
            chain <= {chain[STAGES-2:0], d};
            prev  <= chain[STAGES-1];
        end
    end

    assign q    = chain[STAGES-1];
    assign rise = q & ~prev;
    assign fall = ~q & prev;
endmodule

// File: rtl/led_panel_capture.sv
// rtl/led_panel_capture.sv - passive HUB panel sink rebuilding the 8x32 image
module led_panel_capture
    import led_panel_pkg::*;
#(
    parameter int COLS        = PANEL_COLS,
    parameter int ROW_ADDRS   = PANEL_ROW_ADDRS,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    led_panel_capture_if.slave  hub,
    input  logic [HALF_W-1:0]   rd_row,
    input  logic [4:0]          rd_col,
    output logic [2:0]          rd_rgb,
    output row_addr_t           row_addr,
    output logic                frame_done,
    output logic                lit,
    output logic                shift_err
);
    logic sclk_s, sclk_rise, sclk_fall;
    logic latch_s, latch_rise, latch_fall;
    logic blank_s, blank_rise, blank_fall;
    logic aclk_s, aclk_rise, aclk_fall;
    logic arst_s, arst_rise, arst_fall;
    logic [2:0] rgb_s, rgb_rise, rgb_fall;

    // Idle-high pins reset high so release never looks like an edge.
    led_panel_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sclk (
        .clk(clk), .reset(reset), .d(hub.sclk_in),
        .q(sclk_s), .rise(sclk_rise), .fall(sclk_fall));
    led_panel_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_latch (
        .clk(clk), .reset(reset), .d(hub.latch_in),
        .q(latch_s), .rise(latch_rise), .fall(latch_fall));
    led_panel_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_blank (
        .clk(clk), .reset(reset), .d(hub.blank_in),
        .q(blank_s), .rise(blank_rise), .fall(blank_fall));
    led_panel_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_aclk (
        .clk(clk), .reset(reset), .d(hub.aclk_in),
        .q(aclk_s), .rise(aclk_rise), .fall(aclk_fall));
    led_panel_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_arst (
        .clk(clk), .reset(reset), .d(hub.arst_in),
        .q(arst_s), .rise(arst_rise), .fall(arst_fall));

    for (genvar b = 0; b < 3; b++) begin : g_rgb
        led_panel_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_rgb (
            .clk(clk), .reset(reset), .d(hub.rgb_in[b]),
            .q(rgb_s[b]), .rise(rgb_rise[b]), .fall(rgb_fall[b]));
    end

    logic unused_edges;
    assign unused_edges = ^{sclk_s, latch_s, latch_fall, blank_rise, blank_fall,
                            aclk_s, aclk_fall, arst_rise, arst_fall, rgb_rise, rgb_fall};

    logic [2:0][COLS-1:0] lo, hi;
    logic [5:0]           fall_cnt, rise_cnt;
    rgb_t                 frame [PANEL_HALF_ROWS][COLS];
    logic [HALF_W-1:0]    up_row, low_row;

    assign up_row  = HALF_W'(row_addr);
    assign low_row = up_row + HALF_W'(ROW_ADDRS);

    always_ff @(posedge clk) begin
        if (reset) begin
            lo         <= '0;
            hi         <= '0;
            fall_cnt   <= '0;
            rise_cnt   <= '0;
            shift_err  <= 1'b0;
            frame_done <= 1'b0;
            lit        <= 1'b0;
            row_addr   <= '0;
            rd_rgb     <= '0;
            for (int r = 0; r < PANEL_HALF_ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    frame[r][c] <= '0;
        end else begin
            frame_done <= latch_rise && (row_addr == ROW_W'(ROW_ADDRS - 1));
            lit        <= ~blank_s;
            rd_rgb     <= frame[rd_row][rd_col];

            if (arst_s)
                row_addr <= '0;
            else if (aclk_rise)
                row_addr <= (row_addr == ROW_W'(ROW_ADDRS - 1)) ? '0 : row_addr + ROW_W'(1);

            for (int b = 0; b < 3; b++) begin
                if (sclk_fall) lo[b] <= {lo[b][COLS-2:0], rgb_s[b]};
                if (sclk_rise) hi[b] <= {hi[b][COLS-2:0], rgb_s[b]};
            end

            // A shift coinciding with the latch is copied pre-shift and counts toward the next row.
            if (latch_rise) begin
                for (int k = 0; k < COLS; k++) begin
                    frame[up_row][k]  <= {hi[2][k], hi[1][k], hi[0][k]};
                    frame[low_row][k] <= {lo[2][k], lo[1][k], lo[0][k]};
                end
                if (fall_cnt != 6'(COLS) || rise_cnt != 6'(COLS))
                    shift_err <= 1'b1;
                fall_cnt <= sclk_fall ? 6'd1 : 6'd0;
                rise_cnt <= sclk_rise ? 6'd1 : 6'd0;
            end else begin
                if (sclk_fall && fall_cnt != 6'd63) fall_cnt <= fall_cnt + 6'd1;
                if (sclk_rise && rise_cnt != 6'd63) rise_cnt <= rise_cnt + 6'd1;
            end
        end
    end
endmodule

// File: tb/tb_led_panel_capture.sv
// tb/tb_led_panel_capture.sv - directed self-checking bench for led_panel_capture
module tb_led_panel_capture;
    import led_panel_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] rd_row;
    logic [4:0] rd_col;
    logic [2:0] rd_rgb;
    row_addr_t  row_addr;
    logic       frame_done, lit, shift_err;
    int         passed = 0;
    int         total = 0;
    int         fd_count = 0;

    led_panel_capture_if hub();

    led_panel_capture dut (
        .clk(clk), .reset(reset), .hub(hub),
        .rd_row(rd_row), .rd_col(rd_col), .rd_rgb(rd_rgb),
        .row_addr(row_addr), .frame_done(frame_done), .lit(lit), .shift_err(shift_err));

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_done === 1'b1) fd_count++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pair(input logic [2:0] lo_v, input logic [2:0] hi_v);
        hub.rgb_in = lo_v; hub.sclk_in = 1'b0; cyc(2);
        hub.rgb_in = hi_v; hub.sclk_in = 1'b1; cyc(2);
    endtask

    task automatic shift_row(input int n, input logic [2:0] lo_v, input logic [2:0] hi_v);
        for (int i = 0; i < n; i++) pair(lo_v, hi_v);
    endtask

    task automatic latch_pulse(output logic fd2, output logic fd3);
        hub.latch_in = 1'b1; cyc(2); fd2 = frame_done;
        cyc(1); fd3 = frame_done;
        hub.latch_in = 1'b0; cyc(3);
    endtask

    task automatic aclk_pulse();
        hub.aclk_in = 1'b1; cyc(2); hub.aclk_in = 1'b0; cyc(4);
    endtask

    task automatic arst_pulse();
        hub.arst_in = 1'b1; cyc(2); hub.arst_in = 1'b0; cyc(4);
    endtask

    task automatic reset_pulse();
        reset = 1'b1; cyc(3); reset = 1'b0; cyc(3);
    endtask

    // Coincident latch rise and sclk fall carrying lo_v; the paired rise follows.
    task automatic latch_with_fall(input logic [2:0] lo_v);
        hub.rgb_in = lo_v; hub.sclk_in = 1'b0; hub.latch_in = 1'b1; cyc(2);
        hub.rgb_in = 3'b000; hub.sclk_in = 1'b1; hub.latch_in = 1'b0; cyc(2);
    endtask

    task automatic rd(input logic [2:0] r, input logic [4:0] c, output logic [2:0] v);
        rd_row = r; rd_col = c; cyc(1); v = rd_rgb;
    endtask

    task automatic scan(input int ra, input int rb, input logic [2:0] band,
                        input int sr, input int sc, input logic [2:0] sv, output int bad);
        logic [2:0] v, e;
        bad = 0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 32; c++) begin
                rd(3'(r), 5'(c), v);
                e = (r == ra || r == rb) ? band : 3'b000;
                if (r == sr && c == sc) e = sv;
                if (v !== e) bad++;
            end
        end
    endtask

    initial begin
        logic [2:0] v;
        logic       fd2, fd3;
        int         bad, fd_start;

        reset = 1'b1;
        hub.sclk_in = 1'b1; hub.latch_in = 1'b0; hub.blank_in = 1'b1;
        hub.aclk_in = 1'b0; hub.arst_in = 1'b0; hub.rgb_in = 3'b000;
        rd_row = 3'd0; rd_col = 5'd0;
        cyc(3);
        reset = 1'b0; cyc(3);

        check("reset_row_addr", 32'(row_addr), 0);
        check("reset_shift_err", 32'(shift_err), 0);
        check("reset_frame_done", 32'(frame_done), 0);
        check("reset_lit", 32'(lit), 0);
        check("reset_rd_rgb", 32'(rd_rgb), 0);

        hub.blank_in = 1'b0; cyc(4);
        check("lit_on", 32'(lit), 1);
        hub.blank_in = 1'b1; cyc(4);
        check("lit_off", 32'(lit), 0);

        // 1: single red bit on the 10th fall lands in lower row 4, column 22
        for (int i = 0; i < 32; i++) pair((i == 9) ? 3'b100 : 3'b000, 3'b000);
        latch_pulse(fd2, fd3);
        check("t1_shift_err", 32'(shift_err), 0);
        rd(3'd4, 5'd22, v);
        check("t1_px_4_22", 32'(v), 32'h4);
        scan(-1, -1, 3'b000, 4, 22, 3'b100, bad);
        check("t1_scan_bad", 32'(bad), 0);

        // 2: four rows, frame_done once after row 3
        fd_start = fd_count;
        arst_pulse();
        check("t2_arst_row", 32'(row_addr), 0);
        for (int r = 0; r < 4; r++) begin
            shift_row(32, 3'(7 - r), 3'(r + 1));
            latch_pulse(fd2, fd3);
            check("t2_fd_early", 32'(fd2), 0);
            check("t2_fd_pulse", 32'(fd3), (r == 3) ? 1 : 0);
            check("t2_row_at_latch", 32'(row_addr), 32'(r));
            if (r < 3) aclk_pulse();
        end
        check("t2_fd_count", 32'(fd_count - fd_start), 1);
        check("t2_shift_err", 32'(shift_err), 0);
        rd(3'd1, 5'd5, v);  check("t2_px_1_5", 32'(v), 2);
        rd(3'd5, 5'd5, v);  check("t2_px_5_5", 32'(v), 6);
        rd(3'd3, 5'd0, v);  check("t2_px_3_0", 32'(v), 4);
        rd(3'd7, 5'd31, v); check("t2_px_7_31", 32'(v), 4);
        rd(3'd0, 5'd17, v); check("t2_px_0_17", 32'(v), 1);
        rd(3'd4, 5'd17, v); check("t2_px_4_17", 32'(v), 7);
        arst_pulse();
        check("t2_arst_return", 32'(row_addr), 0);

        // 3: short row sets a sticky error
        shift_row(31, 3'b001, 3'b010);
        latch_pulse(fd2, fd3);
        check("t3_err_set", 32'(shift_err), 1);
        aclk_pulse();
        shift_row(32, 3'b000, 3'b000);
        latch_pulse(fd2, fd3);
        check("t3_err_sticky", 32'(shift_err), 1);
        reset_pulse();
        check("t3_err_cleared", 32'(shift_err), 0);

        // 4: arst dominates aclk, then wrap 3 -> 0
        aclk_pulse();
        check("t4_step1", 32'(row_addr), 1);
        hub.arst_in = 1'b1; cyc(4);
        check("t4_arst_held", 32'(row_addr), 0);
        aclk_pulse();
        check("t4_aclk_under_arst", 32'(row_addr), 0);
        hub.arst_in = 1'b0; cyc(4);
        for (int i = 0; i < 3; i++) aclk_pulse();
        check("t4_row3", 32'(row_addr), 3);
        aclk_pulse();
        check("t4_wrap", 32'(row_addr), 0);

        // 5: reset mid-row discards partial data
        shift_row(16, 3'b111, 3'b111);
        reset_pulse();
        aclk_pulse(); aclk_pulse();
        check("t5_row2", 32'(row_addr), 2);
        shift_row(32, 3'b011, 3'b011);
        latch_pulse(fd2, fd3);
        check("t5_shift_err", 32'(shift_err), 0);
        rd(3'd2, 5'd31, v); check("t5_px_2_31", 32'(v), 3);
        rd(3'd6, 5'd0, v);  check("t5_px_6_0", 32'(v), 3);
        scan(2, 6, 3'b011, -1, -1, 3'b000, bad);
        check("t5_scan_bad", 32'(bad), 0);

        // 6: latch coincident with an sclk fall
        arst_pulse();
        shift_row(32, 3'b001, 3'b000);
        latch_with_fall(3'b110);
        check("t6_no_err_first", 32'(shift_err), 0);
        rd(3'd4, 5'd0, v);  check("t6_px_4_0_preshift", 32'(v), 1);
        rd(3'd4, 5'd31, v); check("t6_px_4_31_preshift", 32'(v), 1);
        shift_row(31, 3'b010, 3'b000);
        latch_pulse(fd2, fd3);
        check("t6_31_more_ok", 32'(shift_err), 0);
        rd(3'd4, 5'd31, v); check("t6_carry_bit", 32'(v), 6);
        rd(3'd4, 5'd30, v); check("t6_px_4_30", 32'(v), 2);
        rd(3'd4, 5'd0, v);  check("t6_px_4_0", 32'(v), 2);
        latch_with_fall(3'b000);
        shift_row(32, 3'b000, 3'b000);
        latch_pulse(fd2, fd3);
        check("t6_32_more_err", 32'(shift_err), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
